rsa_avalon_wrapper: RTL and testbench
=====================================

# rsa_avalon_wrapper

Host-side front end for the RSA256 decryption core. Acts as an Avalon-MM master to the RS232 UART core: it polls UART status, collects the 256-bit modulus N, private exponent D and ciphertext Y byte by byte, pulses the core's start, and streams the 248-bit plaintext back out through the UART. Sits directly upstream and downstream of the RSA256 core and drives its start/operand ports.

## Interface
Parameters:
- RX_BASE, 0, UART RX data register address.
- TX_BASE, 4, UART TX data register address.
- STATUS_BASE, 8, UART status register address.
- RX_OK_BIT, 7, status bit: RX byte available.
- TX_OK_BIT, 6, status bit: TX ready.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- avm_address  out  5  Avalon address.
- avm_read  out  1  read request.
- avm_readdata  in  32  read data; only [7:0] or the status bit is used.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data, {24'b0, byte}.
- avm_waitrequest  in  1  slave stall.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_a  out  256  ciphertext Y.
- o_core_d  out  256  exponent D.
- o_core_n  out  256  modulus N.
- i_core_a_pow_d  in  256  core result.
- i_core_finished  in  1  core done pulse.

## Operation
- Phases (2-bit): P_N, P_D, P_Y. Reset phase is P_N.
- States: S_QUERY_RX, S_READ, S_START, S_WAIT, S_QUERY_TX, S_WRITE. Reset state is S_QUERY_RX.
- S_QUERY_RX: read=1, address=STATUS_BASE. On an accepted read (waitrequest=0): if readdata[RX_OK_BIT] then go to S_READ, else stay and re-poll.
- S_READ: read=1, address=RX_BASE. On accept, shift the byte into the phase's register MSB-first (reg <= {reg[247:0], readdata[7:0]}) and increment the byte counter.
  - If the counter was 31: clear it and advance the phase (P_N->P_D, P_D->P_Y, P_Y->S_START). Otherwise return to S_QUERY_RX.
- S_START: o_core_start=1 for exactly one cycle, then go to S_WAIT. o_core_a/d/n stay stable from start until the next Y byte is shifted.
- S_WAIT: on i_core_finished, capture i_core_a_pow_d into the output shift register and go to S_QUERY_TX. Ignore i_core_finished in all other states.
- S_QUERY_TX: read=1, address=STATUS_BASE. On accept: if readdata[TX_OK_BIT] then go to S_WRITE, else re-poll.
- S_WRITE: write=1, address=TX_BASE, writedata={24'b0, out[247:240]}. On accept, shift out left by 8 and increment the counter.
  - After 31 bytes: clear the counter and go to S_QUERY_RX with phase P_Y (N and D are retained). Otherwise go to S_QUERY_TX.
- Byte counter is 5 bits; it wraps 31->0 only via the explicit clear.

## Timing
- Reset values: avm_read=0, avm_write=0, avm_address=STATUS_BASE, avm_writedata=0, o_core_start=0, o_core_a/d/n=0, counter=0, output register=0.
- Avalon rule: address, read/write and writedata are held constant while waitrequest=1. A transfer completes in the cycle waitrequest=0. Read and write are never asserted together.
- Outputs are registered; request signals change on the cycle after the accept.
- With a zero-wait slave and data always ready, each RX byte and each TX byte takes 2 cycles (poll + data).
- Start to capture latency is set by the core; the wrapper adds 1 cycle (S_START) plus 1 cycle of capture.
- Reset asserted mid-operation returns immediately to the reset values. Partially received bytes and keys are discarded.
- A status poll that returns "not ready" never advances the counter or the phase.

## Configuration
- RSA_WRAP_KEY_RELOAD_EN defined: after the 31st TX byte, the phase returns to P_N, so every block requires N, D and Y (96 bytes).
- Undefined (default): N and D are loaded once after reset; subsequent blocks send only Y (32 bytes).

## Test plan
- Key load: send 31x00,21 then 31x00,07 then 31x00,1A. Expect o_core_n=0x21, o_core_d=0x07, o_core_a=0x1A, one o_core_start pulse. With a core model, the TX stream is 30x00 then 05.
- Second block (macro off): send 31x00,1A only. Expect the identical 31-byte output 30x00,05 and no key re-read.
- Macro on: after the first block, sending 32 Y bytes does not start the core; the wrapper treats them as N.
- Backpressure: waitrequest random 0-5 cycles, RX_OK low for 10 polls between bytes. Expect signals held, no lost or duplicated byte, same result.
- Reset asserted after 17 N bytes: outputs return to reset values. A fresh 96-byte sequence then decrypts correctly.
- Spurious i_core_finished during S_QUERY_RX: no state change, no TX write.

Source files
------------

// File: rtl/rsa_avalon_wrapper.sv
// Avalon-MM master between the UART and the RSA256 core: gathers N, D, Y byte by byte, starts the core, streams the 248-bit plaintext back.
// Build option RSA_WRAP_KEY_RELOAD_EN: when defined, N and D are re-received for every block instead of once after reset.
module rsa_avalon_wrapper #(
  parameter int unsigned RX_BASE     = 0,
  parameter int unsigned TX_BASE     = 4,
  parameter int unsigned STATUS_BASE = 8,
  parameter int unsigned RX_OK_BIT   = 7,
  parameter int unsigned TX_OK_BIT   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
);

  typedef enum logic [2:0] {
    S_QUERY_RX = 3'd0,
    S_READ     = 3'd1,
    S_START    = 3'd2,
    S_WAIT     = 3'd3,
    S_QUERY_TX = 3'd4,
    S_WRITE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    P_N = 2'd0,
    P_D = 2'd1,
    P_Y = 2'd2
  } phase_t;

  state_t         state_q;
  state_t         state_d;
  phase_t         phase_q;
  logic [4:0]     cnt_q;
  logic [247:0]   out_q;

  logic           rd_acc;
  logic           wr_acc;
  logic           last_rx;
  logic           last_tx;
  logic [7:0]     rx_byte;

  logic [4:0]     address_d;
  logic           read_d;
  logic           write_d;
  logic [31:0]    writedata_d;
  logic           start_d;

  logic           unused_bits;

  // A transfer only completes when the request is actually on the bus.
  assign rd_acc  = avm_read  && !avm_waitrequest;
  assign wr_acc  = avm_write && !avm_waitrequest;
  assign last_rx = (cnt_q == 5'd31);
  assign last_tx = (cnt_q == 5'd30);
  assign rx_byte = avm_readdata[7:0];

  assign unused_bits = ^{avm_readdata[31:8], i_core_a_pow_d[255:248]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_QUERY_RX;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_QUERY_RX: begin
        if (rd_acc && avm_readdata[RX_OK_BIT]) state_d = S_READ;
      end
      S_READ: begin
        if (rd_acc) begin
          if (last_rx && phase_q == P_Y) state_d = S_START;
          else                           state_d = S_QUERY_RX;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) state_d = S_QUERY_TX;
      end
      S_QUERY_TX: begin
        if (rd_acc && avm_readdata[TX_OK_BIT]) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (last_tx) state_d = S_QUERY_RX;
          else         state_d = S_QUERY_TX;
        end
      end
      default: begin
        state_d = S_QUERY_RX;
      end
    endcase
  end

  // Bus requests are decoded from the next state and registered, so a stalled
  // request holds automatically (the state does not move without an accept).
  always_comb begin
    address_d   = 5'(STATUS_BASE);
    read_d      = 1'b0;
    write_d     = 1'b0;
    writedata_d = 32'd0;
    start_d     = 1'b0;
    case (state_d)
      S_QUERY_RX: begin
        read_d    = 1'b1;
        address_d = 5'(STATUS_BASE);
      end
      S_READ: begin
        read_d    = 1'b1;
        address_d = 5'(RX_BASE);
      end
      S_START: begin
        start_d = 1'b1;
      end
      S_QUERY_TX: begin
        read_d    = 1'b1;
        address_d = 5'(STATUS_BASE);
      end
      S_WRITE: begin
        write_d     = 1'b1;
        address_d   = 5'(TX_BASE);
        writedata_d = {24'd0, out_q[247:240]};
      end
      default: begin
        address_d = 5'(STATUS_BASE);
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      avm_address   <= 5'(STATUS_BASE);
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'd0;
      o_core_start  <= 1'b0;
    end else begin
      avm_address   <= address_d;
      avm_read      <= read_d;
      avm_write     <= write_d;
      avm_writedata <= writedata_d;
      o_core_start  <= start_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q  <= P_N;
      cnt_q    <= 5'd0;
      out_q    <= '0;
      o_core_n <= '0;
      o_core_d <= '0;
      o_core_a <= '0;
    end else begin
      if (state_q == S_READ && rd_acc) begin
        case (phase_q)
          P_N:     o_core_n <= {o_core_n[247:0], rx_byte};
          P_D:     o_core_d <= {o_core_d[247:0], rx_byte};
          default: o_core_a <= {o_core_a[247:0], rx_byte};
        endcase
        if (last_rx) begin
          cnt_q <= 5'd0;
          case (phase_q)
            P_N:     phase_q <= P_D;
            default: phase_q <= P_Y;
          endcase
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end

      if (state_q == S_WAIT && i_core_finished) begin
        out_q <= i_core_a_pow_d[247:0];
      end

      if (state_q == S_WRITE && wr_acc) begin
        out_q <= {out_q[239:0], 8'd0};
        if (last_tx) begin
          cnt_q <= 5'd0;
`ifdef RSA_WRAP_KEY_RELOAD_EN
          phase_q <= P_N;
`else
          phase_q <= P_Y;
`endif
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rsa_avalon_wrapper.sv
// Bench for rsa_avalon_wrapper: UART slave model, small modexp core model, directed key/ciphertext vectors.
module tb_rsa_avalon_wrapper;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [4:0]   avm_address;
  logic         avm_read;
  logic [31:0]  avm_readdata;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest;
  logic         o_core_start;
  logic [255:0] o_core_a;
  logic [255:0] o_core_d;
  logic [255:0] o_core_n;
  logic [255:0] i_core_a_pow_d;
  logic         i_core_finished;

  rsa_avalon_wrapper dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_d        (o_core_d),
    .o_core_n        (o_core_n),
    .i_core_a_pow_d  (i_core_a_pow_d),
    .i_core_finished (i_core_finished)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Written only by the main sequence.
  logic [7:0] rx_buf [0:511];
  int         rx_len = 0;
  bit         bp = 1'b0;
  logic       spurious_fin = 1'b0;

  // Written only by the UART slave model.
  int         rx_rd = 0;
  logic [7:0] tx_buf [0:255];
  int         tx_cnt = 0;
  int         proto_errs = 0;

  // Written only by the core model.
  int           start_cnt = 0;
  logic         core_fin = 1'b0;
  logic [255:0] core_res = '0;

  assign i_core_finished = core_fin | spurious_fin;
  assign i_core_a_pow_d  = core_res;

  function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                          input logic [255:0] n);
    longint unsigned r, b, m;
    m = longint'(n[15:0]);
    if (m == 0) return '0;
    r = 1 % m;
    b = longint'(a[15:0]) % m;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return 256'(r);
  endfunction

  // UART slave: decides stall/response on the falling edge for the next rising edge.
  initial begin : uart_model
    int         wait_cnt;
    int         rx_nr;
    int         tx_nr;
    bit         stalled;
    logic [39:0] held;
    logic       rx_ok;
    logic       tx_ok;
    wait_cnt = 0; rx_nr = 0; tx_nr = 0; stalled = 0; held = '0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        rx_rd = 0; tx_cnt = 0; wait_cnt = 0; rx_nr = 0; tx_nr = 0; stalled = 0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
      end else begin
        if (avm_read && avm_write) proto_errs++;
        if (stalled && {avm_address, avm_read, avm_write, avm_writedata} != held) proto_errs++;
        if (!(avm_read || avm_write)) begin
          avm_waitrequest = 1'b0;
          stalled = 0;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
          avm_waitrequest = 1'b1;
          stalled = 1;
          held = {avm_address, avm_read, avm_write, avm_writedata};
        end else begin
          avm_waitrequest = 1'b0;
          stalled = 0;
          wait_cnt = bp ? $urandom_range(0, 5) : 0;
          if (avm_write) begin
            if (avm_address != 5'd4 || avm_writedata[31:8] != 24'd0) proto_errs++;
            tx_buf[tx_cnt] = avm_writedata[7:0];
            tx_cnt++;
            tx_nr = bp ? 2 : 0;
          end else if (avm_address == 5'd8) begin
            rx_ok = (rx_rd < rx_len) && (rx_nr == 0);
            if (rx_rd < rx_len && rx_nr > 0) rx_nr--;
            tx_ok = (tx_nr == 0);
            if (tx_nr > 0) tx_nr--;
            avm_readdata = {24'd0, rx_ok, tx_ok, 6'd0};
          end else begin
            if (avm_address != 5'd0 || rx_rd >= rx_len) proto_errs++;
            avm_readdata = {24'd0, rx_buf[rx_rd]};
            rx_rd++;
            rx_nr = bp ? 10 : 0;
          end
        end
      end
    end
  end

  // Core model: fixed latency after start, result from the operands seen at start.
  initial begin : core_model
    int timer;
    timer = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        start_cnt = 0; timer = 0; core_fin = 1'b0;
      end else begin
        core_fin = 1'b0;
        if (timer > 0) begin
          timer--;
          if (timer == 0) core_fin = 1'b1;
        end
        if (o_core_start) begin
          start_cnt++;
          core_res = modexp(o_core_a, o_core_d, o_core_n);
          timer = 6;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_operand(input logic [7:0] lsb);
    for (int i = 0; i < 31; i++) begin
      rx_buf[rx_len] = 8'h00;
      rx_len++;
    end
    rx_buf[rx_len] = lsb;
    rx_len++;
  endtask

  task automatic wait_tx(input int target, input string name);
    int cyc;
    cyc = 0;
    while (tx_cnt < target && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
    end
    if (tx_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout with %0d tx bytes, expected %0d", name, tx_cnt, target);
    end
  endtask

  task automatic wait_rx(input int target, input string name);
    int cyc;
    cyc = 0;
    while (rx_rd < target && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
    end
    if (rx_rd < target) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout with %0d rx bytes, expected %0d", name, rx_rd, target);
    end
  endtask

  task automatic check_tx(input int base, input logic [7:0] pt, input string name);
    logic [247:0] got;
    got = '0;
    for (int k = 0; k < 31; k++) got = {got[239:0], tx_buf[base + k]};
    chk(name, 256'(got), 256'(pt));
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_bus"}, 256'({avm_read, avm_write, avm_address, avm_writedata, o_core_start}),
        256'({1'b0, 1'b0, 5'd8, 32'd0, 1'b0}));
    chk({name, "_n"}, o_core_n, '0);
    chk({name, "_d"}, o_core_d, '0);
    chk({name, "_a"}, o_core_a, '0);
  endtask

  task automatic do_reset(input string name);
    @(negedge i_clk);
    i_rst = 1'b1;
    rx_len = 0;
    spurious_fin = 1'b0;
    #1;
    check_reset_vals(name);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] y;
    logic [7:0] pt;
    bit         bp;
  } vec_t;

  vec_t vecs [0:4];

  initial begin : main
    logic [255:0] partial;
    vecs[0] = '{n: 8'h21, d: 8'h07, y: 8'h1A, pt: 8'h05, bp: 1'b0};
    vecs[1] = '{n: 8'h21, d: 8'h03, y: 8'h02, pt: 8'h08, bp: 1'b0};
    vecs[2] = '{n: 8'h37, d: 8'h03, y: 8'h04, pt: 8'h09, bp: 1'b0};
    vecs[3] = '{n: 8'hFF, d: 8'h02, y: 8'h10, pt: 8'h01, bp: 1'b0};
    vecs[4] = '{n: 8'h21, d: 8'h07, y: 8'h1A, pt: 8'h05, bp: 1'b1};

    repeat (3) @(negedge i_clk);
    #1;
    check_reset_vals("por");

    for (int v = 0; v < 5; v++) begin
      do_reset($sformatf("rst_v%0d", v));
      bp = vecs[v].bp;
      push_operand(vecs[v].n);
      push_operand(vecs[v].d);
      push_operand(vecs[v].y);
      wait_tx(31, $sformatf("v%0d_tx_wait", v));
      repeat (4) @(negedge i_clk);
      check_tx(0, vecs[v].pt, $sformatf("v%0d_plaintext", v));
      chk($sformatf("v%0d_core_n", v), o_core_n, 256'(vecs[v].n));
      chk($sformatf("v%0d_core_d", v), o_core_d, 256'(vecs[v].d));
      chk($sformatf("v%0d_core_a", v), o_core_a, 256'(vecs[v].y));
      chk($sformatf("v%0d_starts", v), 256'(start_cnt), 256'(1));
      chk($sformatf("v%0d_tx_count", v), 256'(tx_cnt), 256'(31));
      chk($sformatf("v%0d_protocol", v), 256'(proto_errs), 256'(0));
    end

    // Second block after the backpressured key load: only Y is sent.
    bp = 1'b0;
    push_operand(8'h1A);
`ifdef RSA_WRAP_KEY_RELOAD_EN
    wait_rx(128, "blk2_rx_wait");
    repeat (50) @(negedge i_clk);
    chk("blk2_no_start", 256'(start_cnt), 256'(1));
    chk("blk2_y_as_n", o_core_n, 256'(8'h1A));
    chk("blk2_no_tx", 256'(tx_cnt), 256'(31));
`else
    wait_tx(62, "blk2_tx_wait");
    repeat (4) @(negedge i_clk);
    check_tx(31, 8'h05, "blk2_plaintext");
    chk("blk2_starts", 256'(start_cnt), 256'(2));
    chk("blk2_keys_kept", {o_core_n[127:0], o_core_d[127:0]}, {128'h21, 128'h07});
`endif

    // Spurious finish while polling RX with nothing to receive.
    do_reset("rst_spur");
    repeat (20) @(negedge i_clk);
    spurious_fin = 1'b1;
    @(negedge i_clk);
    spurious_fin = 1'b0;
    repeat (50) @(negedge i_clk);
    chk("spur_no_tx", 256'(tx_cnt), 256'(0));
    chk("spur_still_polling", 256'({avm_read, avm_write, avm_address}), 256'({1'b1, 1'b0, 5'd8}));

    // Reset after 17 N bytes, then a clean 96-byte block.
    partial = '0;
    for (int i = 0; i < 17; i++) begin
      rx_buf[rx_len] = 8'hA0 + 8'(i);
      rx_len++;
      partial = {partial[247:0], 8'hA0 + 8'(i)};
    end
    wait_rx(17, "mid_rx_wait");
    repeat (4) @(negedge i_clk);
    chk("mid_partial_n", o_core_n, partial);
    do_reset("rst_mid");
    push_operand(8'h21);
    push_operand(8'h07);
    push_operand(8'h1A);
    wait_tx(31, "mid_tx_wait");
    repeat (4) @(negedge i_clk);
    check_tx(0, 8'h05, "mid_plaintext");
    chk("mid_starts", 256'(start_cnt), 256'(1));
    chk("final_protocol", 256'(proto_errs), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
